// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extension unit (zero/sign/high/branch) with a 2-entry skid buffer.
// Optional accepted-output counter port xfer_cnt enabled by defining IMM_EXT_PERFCNT_EN.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm,
  output logic [TAG_W-1:0] out_tag
`ifdef IMM_EXT_PERFCNT_EN
  ,
  output logic [15:0]      xfer_cnt
`endif
);

  localparam int PAD_W = OUT_W - IN_W;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [OUT_W-1:0]   o_imm_q, o_imm_d, s_imm_q, s_imm_d;
  logic [TAG_W-1:0]   o_tag_q, o_tag_d, s_tag_q, s_tag_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
  logic               acc, drn;
  logic [OUT_W-1:0]   ext_imm;

  function automatic logic [OUT_W-1:0] extend(input logic [1:0] op, input logic [IN_W-1:0] imm);
    logic [OUT_W-1:0] sext;
    sext = {{PAD_W{imm[IN_W-1]}}, imm};
    case (op)
      2'b00:   extend = {{PAD_W{1'b0}}, imm};
      2'b01:   extend = sext;
      2'b10:   extend = {imm, {PAD_W{1'b0}}};
      2'b11:   extend = {sext[OUT_W-3:0], 2'b00};
      default: extend = {OUT_W{1'b0}};
    endcase
  endfunction

  assign acc       = in_valid && in_ready_q;
  assign drn       = out_valid_q && out_ready;
  assign ext_imm   = extend(in_op, in_imm);
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_imm   = o_imm_q;
  assign out_tag   = o_tag_q;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (acc) state_d = ST_ONE;
        else     state_d = ST_EMPTY;
      end
      ST_ONE: begin
        if (acc && !drn)      state_d = ST_FULL;
        else if (!acc && drn) state_d = ST_EMPTY;
        else                  state_d = ST_ONE;
      end
      ST_FULL: begin
        if (drn) state_d = ST_ONE;
        else     state_d = ST_FULL;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Output/datapath logic; handshake flags are precomputed from the next state
  always_comb begin
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_FULL);
    o_imm_d     = o_imm_q;
    o_tag_d     = o_tag_q;
    s_imm_d     = s_imm_q;
    s_tag_d     = s_tag_q;
    case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          o_imm_d = ext_imm;
          o_tag_d = in_tag;
        end else begin
          o_imm_d = o_imm_q;
        end
      end
      ST_ONE: begin
        if (acc && drn) begin
          o_imm_d = ext_imm;
          o_tag_d = in_tag;
        end else if (acc) begin
          s_imm_d = ext_imm;
          s_tag_d = in_tag;
        end else begin
          o_imm_d = o_imm_q;
        end
      end
      ST_FULL: begin
        if (drn) begin
          o_imm_d = s_imm_q;
          o_tag_d = s_tag_q;
        end else begin
          o_imm_d = o_imm_q;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // Output and skid registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_imm_q     <= {OUT_W{1'b0}};
      o_tag_q     <= {TAG_W{1'b0}};
      s_imm_q     <= {OUT_W{1'b0}};
      s_tag_q     <= {TAG_W{1'b0}};
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      o_imm_q     <= o_imm_d;
      o_tag_q     <= o_tag_d;
      s_imm_q     <= s_imm_d;
      s_tag_q     <= s_tag_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

`ifdef IMM_EXT_PERFCNT_EN
  logic [15:0] xfer_cnt_q, xfer_cnt_d;

  // Output transfer counter, wraps naturally
  always_comb begin
    if (drn) xfer_cnt_d = xfer_cnt_q + 16'd1;
    else     xfer_cnt_d = xfer_cnt_q;
  end

  // Counter register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      xfer_cnt_q <= 16'd0;
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: vector table, stall/order sequences, async reset, narrow instance.
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_op;
  logic [4:0]  in_tag, out_tag;
  logic [31:0] out_imm;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  in_imm8;
  logic [1:0]  in_op8;
  logic [4:0]  in_tag8, out_tag8;
  logic [15:0] out_imm8;

`ifdef IMM_EXT_PERFCNT_EN
  logic [15:0] xfer_cnt, xfer_cnt8;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imm_extend_pipe u_dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_tag(out_tag)
`ifdef IMM_EXT_PERFCNT_EN
    , .xfer_cnt(xfer_cnt)
`endif
  );

  imm_extend_pipe #(.IN_W(8), .OUT_W(16), .TAG_W(5)) u_dut8 (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_imm(in_imm8), .in_op(in_op8), .in_tag(in_tag8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_imm(out_imm8), .out_tag(out_tag8)
`ifdef IMM_EXT_PERFCNT_EN
    , .xfer_cnt(xfer_cnt8)
`endif
  );

  typedef struct {
    logic [1:0]  op;
    logic [15:0] imm;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference extension written from the arithmetic definition
  function automatic logic [31:0] ref_ext(input logic [1:0] op, input logic [15:0] imm);
    logic signed [31:0] s;
    s = $signed(imm);
    case (op)
      2'b00:   return {16'h0000, imm};
      2'b01:   return s;
      2'b10:   return {imm, 16'h0000};
      default: return s <<< 2;
    endcase
  endfunction

  initial begin
    logic [36:0] q[$];
    logic [36:0] exp_e;
    logic [31:0] hold_imm;
    logic [4:0]  hold_tag;
    logic        stall, acc, drn;
    int          sent;
    int          cyc;

    vecs[0] = '{2'b00, 16'h8001, 5'd1, 32'h00008001};
    vecs[1] = '{2'b01, 16'h8001, 5'd2, 32'hFFFF8001};
    vecs[2] = '{2'b10, 16'h8001, 5'd3, 32'h80010000};
    vecs[3] = '{2'b11, 16'h8001, 5'd4, 32'hFFFE0004};
    vecs[4] = '{2'b01, 16'h7FFF, 5'd5, 32'h00007FFF};
    vecs[5] = '{2'b11, 16'h7FFF, 5'd6, 32'h0001FFFC};
    vecs[6] = '{2'b10, 16'hFFFF, 5'd7, 32'hFFFF0000};
    vecs[7] = '{2'b00, 16'hFFFF, 5'd8, 32'h0000FFFF};

    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_imm = 16'h0; in_op = 2'b00; in_tag = 5'd0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; in_imm8 = 8'h0; in_op8 = 2'b00; in_tag8 = 5'd0;
    step(); step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_imm", out_imm, 32'd0);
    chk("rst_out_tag", {27'd0, out_tag}, 32'd0);
    @(negedge clk) rstn = 1'b1;
    step();

    // Back-to-back stream, one beat per cycle, one-cycle latency
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_op = vecs[i].op; in_imm = vecs[i].imm; in_tag = vecs[i].tag;
      step();
      chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("vec%0d_imm", i), out_imm, vecs[i].exp);
      chk($sformatf("vec%0d_tag", i), {27'd0, out_tag}, {27'd0, vecs[i].tag});
      chk($sformatf("vec%0d_ready", i), {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("drain_empty", {31'd0, out_valid}, 32'd0);

    // Stalled downstream fills skid buffer, then drains in order
    out_ready = 1'b0; in_valid = 1'b1; in_op = 2'b00;
    in_tag = 5'd1; in_imm = 16'h0001; step();
    chk("stall_t1_ready", {31'd0, in_ready}, 32'd1);
    chk("stall_t1_tag", {27'd0, out_tag}, 32'd1);
    in_tag = 5'd2; in_imm = 16'h0002; step();
    chk("stall_full_ready", {31'd0, in_ready}, 32'd0);
    chk("stall_full_tag", {27'd0, out_tag}, 32'd1);
    in_tag = 5'd3; in_imm = 16'h0003; step();
    chk("stall_hold_ready", {31'd0, in_ready}, 32'd0);
    chk("stall_hold_imm", out_imm, 32'h00000001);
    out_ready = 1'b1; step();
    chk("drain_t2_tag", {27'd0, out_tag}, 32'd2);
    chk("drain_t2_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("drain_t3_tag", {27'd0, out_tag}, 32'd3);
    chk("drain_t3_imm", out_imm, 32'h00000003);
    in_valid = 1'b0; step();
    chk("drain2_empty", {31'd0, out_valid}, 32'd0);

    // Random stream against alternating out_ready, scoreboard ordering
    sent = 0; cyc = 0;
    while ((sent < 20 || q.size() != 0) && cyc < 200) begin
      out_ready = cyc[0];
      if (sent < 20) begin
        in_valid = 1'b1; in_imm = 16'($urandom); in_op = 2'($urandom); in_tag = 5'(sent);
      end else begin
        in_valid = 1'b0;
      end
      acc = in_valid && in_ready;
      drn = out_valid && out_ready;
      if (drn) begin
        if (q.size() == 0) begin
          chk("rand_spurious", {31'd0, out_valid}, 32'd0);
        end else begin
          exp_e = q.pop_front();
          chk("rand_imm", out_imm, exp_e[31:0]);
          chk("rand_tag", {27'd0, out_tag}, {27'd0, exp_e[36:32]});
        end
      end
      if (acc) begin
        q.push_back({in_tag, ref_ext(in_op, in_imm)});
        sent++;
      end
      stall = out_valid && !out_ready;
      hold_imm = out_imm; hold_tag = out_tag;
      step();
      if (stall) begin
        chk("stall_stable_imm", out_imm, hold_imm);
        chk("stall_stable_tag", {27'd0, out_tag}, {27'd0, hold_tag});
      end
      cyc++;
    end
    chk("rand_complete", sent + q.size() * 100, 32'd20);
    in_valid = 1'b0; out_ready = 1'b1; step(); step();

    // Asynchronous reset while FULL
    out_ready = 1'b0; in_valid = 1'b1; in_op = 2'b01;
    in_imm = 16'h1111; in_tag = 5'd9; step();
    in_imm = 16'h2222; in_tag = 5'd10; step();
    in_valid = 1'b0;
    chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
    #2 rstn = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_out_imm", out_imm, 32'd0);
    @(negedge clk) rstn = 1'b1;
    in_valid = 1'b1; in_imm = 16'h0004; in_op = 2'b11; in_tag = 5'd11; out_ready = 1'b1;
    step();
    chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
    chk("post_rst_imm", out_imm, 32'h00000010);
    in_valid = 1'b0; step();

    // Narrow instance IN_W=8, OUT_W=16
    in_valid8 = 1'b1; in_imm8 = 8'h80;
    in_op8 = 2'b01; step(); chk("w8_sign", {16'd0, out_imm8}, 32'h0000FF80);
    in_op8 = 2'b10; step(); chk("w8_high", {16'd0, out_imm8}, 32'h00008000);
    in_op8 = 2'b00; step(); chk("w8_zero", {16'd0, out_imm8}, 32'h00000080);
    in_op8 = 2'b11; step(); chk("w8_branch", {16'd0, out_imm8}, 32'h0000FE00);
    in_valid8 = 1'b0; step();

`ifdef IMM_EXT_PERFCNT_EN
    @(negedge clk) rstn = 1'b0;
    @(negedge clk) rstn = 1'b1;
    #1;
    chk("cnt_reset", {16'd0, xfer_cnt}, 32'd0);
    in_valid = 1'b1; out_ready = 1'b1; in_op = 2'b00; in_imm = 16'h0001;
    for (int i = 0; i < 65538; i++) step();
    chk("cnt_wrap", {16'd0, xfer_cnt}, 32'd1);
    in_valid = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
